// File: rtl/approx_adder_pkg.sv
// Shared encodings and default sizing for the approximate adder pipeline.
package approx_adder_pkg;
  localparam int WIDTH_DEF       = 8;
  localparam int APPROX_BITS_DEF = 3;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic {
    MODE_EXACT = 1'b0,
    MODE_LOA   = 1'b1
  } mode_e;
endpackage

// File: rtl/approx_adder_core.sv
// Stateless sum/carry logic: low-part add or OR, upper-part add, and the exact reference sum.
module approx_adder_core
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int APPROX_BITS = APPROX_BITS_DEF
) (
  input  logic [APPROX_BITS-1:0]     lo_a,
  input  logic [APPROX_BITS-1:0]     lo_b,
  input  logic                       lo_cin,
  input  mode_e                      lo_mode,
  output logic [APPROX_BITS-1:0]     lo_sum,
  output logic                       lo_carry,
  input  logic [WIDTH-APPROX_BITS-1:0] hi_a,
  input  logic [WIDTH-APPROX_BITS-1:0] hi_b,
  input  logic                       hi_carry,
  output logic [WIDTH-APPROX_BITS:0] hi_sum,
  input  logic [WIDTH-1:0]           ex_a,
  input  logic [WIDTH-1:0]           ex_b,
  input  logic                       ex_cin,
  output logic [WIDTH:0]             ex_sum
);
  localparam int L = APPROX_BITS;
  localparam int H = WIDTH - APPROX_BITS;

  logic [L:0] lo_ext_s;

  // Low part: exact ripple add, or OR with a carry guessed from the top approximated bit.
  always_comb begin
    lo_ext_s = {1'b0, lo_a} + {1'b0, lo_b} + {{L{1'b0}}, lo_cin};
    lo_sum   = lo_ext_s[L-1:0];
    lo_carry = lo_ext_s[L];
    case (lo_mode)
      MODE_EXACT: begin
        lo_sum   = lo_ext_s[L-1:0];
        lo_carry = lo_ext_s[L];
      end
      MODE_LOA: begin
        lo_sum   = lo_a | lo_b;
        lo_carry = lo_a[L-1] & lo_b[L-1];
      end
      default: begin
        lo_sum   = lo_ext_s[L-1:0];
        lo_carry = lo_ext_s[L];
      end
    endcase
  end

  // Upper part and the exact sum used to flag approximation error.
  always_comb begin
    hi_sum = {1'b0, hi_a} + {1'b0, hi_b} + {{H{1'b0}}, hi_carry};
    ex_sum = {1'b0, ex_a} + {1'b0, ex_b} + {{WIDTH{1'b0}}, ex_cin};
  end
endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready pipeline around approx_adder_core with a saturating error counter.
module approx_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int APPROX_BITS = APPROX_BITS_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  input  logic             cnt_clr
);
  localparam int L = APPROX_BITS;
  localparam int H = WIDTH - APPROX_BITS;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic             s1_cin_r;
  mode_e            s1_mode_r;
  logic [L-1:0]     s1_lo_r;
  logic             s1_carry_r;

  logic [L-1:0]     lo_sum_s;
  logic             lo_carry_s;
  logic [H:0]       hi_sum_s;
  logic [WIDTH:0]   ex_sum_s;
  logic [WIDTH:0]   full_sum_s;
  logic             s2_load_s;
  logic             s1_adv_s;
  logic             s1_load_s;
  logic             deliver_s;

  assign s2_load_s  = !out_valid || out_ready;
  assign s1_adv_s   = s1_valid_r && s2_load_s;
  assign s1_load_s  = !s1_valid_r || s1_adv_s;
  assign in_ready   = rst_n && s1_load_s;
  assign deliver_s  = out_valid && out_ready;
  assign full_sum_s = {hi_sum_s, s1_lo_r};

  approx_adder_core #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (APPROX_BITS)
  ) u_core (
    .lo_a     (a[L-1:0]),
    .lo_b     (b[L-1:0]),
    .lo_cin   (cin),
    .lo_mode  (mode_e'(mode)),
    .lo_sum   (lo_sum_s),
    .lo_carry (lo_carry_s),
    .hi_a     (s1_a_r[WIDTH-1:L]),
    .hi_b     (s1_b_r[WIDTH-1:L]),
    .hi_carry (s1_carry_r),
    .hi_sum   (hi_sum_s),
    .ex_a     (s1_a_r),
    .ex_b     (s1_b_r),
    .ex_cin   (s1_cin_r),
    .ex_sum   (ex_sum_s)
  );

  // Stage 1: capture operands plus the low-part result and carry into the upper part.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_cin_r   <= 1'b0;
      s1_mode_r  <= MODE_EXACT;
      s1_lo_r    <= '0;
      s1_carry_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r     <= a;
        s1_b_r     <= b;
        s1_cin_r   <= cin;
        s1_mode_r  <= mode_e'(mode);
        s1_lo_r    <= lo_sum_s;
        s1_carry_r <= lo_carry_s;
      end
    end
  end

  // Stage 2: finish the upper add and flag any difference from the exact sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      err_flag  <= 1'b0;
    end else if (s2_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        sum      <= full_sum_s;
        err_flag <= (s1_mode_r == MODE_LOA) && (full_sum_s != ex_sum_s);
      end
    end
  end

  // Saturating count of erroneous beats actually handed downstream; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (cnt_clr) begin
      err_count <= '0;
    end else if (deliver_s && err_flag && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_approx_adder_pipe.sv
// Randomized and directed self-checking bench for approx_adder_pipe against an arithmetic reference model.
module tb_approx_adder_pipe;
  localparam int W  = 8;
  localparam int L  = 3;
  localparam int CW = 4;
  localparam int SW = W + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, cin, mode;
  logic          out_valid, out_ready, err_flag, cnt_clr;
  logic [W-1:0]  a, b;
  logic [W:0]    sum;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  approx_adder_pipe #(.WIDTH(W), .APPROX_BITS(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .err_flag(err_flag), .err_count(err_count), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [W:0] s;
    logic       e;
    int         t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mcount = 0;
  int   last_lat = 0;
  bit   use_exp = 1'b0;
  logic [W:0] exp_s;
  logic       exp_e;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference result straight from the arithmetic rules of each mode.
  function automatic logic [W:0] ref_sum(int unsigned x, int unsigned y, int unsigned c, int unsigned m);
    int unsigned lo, hi;
    if (m == 0) return SW'(x + y + c);
    lo = (x | y) % (1 << L);
    hi = (x >> L) + (y >> L) + ((x >> (L - 1)) & (y >> (L - 1)) & 1);
    return SW'(hi * (1 << L) + lo);
  endfunction

  // One clock: evaluate the handshakes before the edge, update the model, check the counter after it.
  task automatic step(output bit acc);
    exp_t e;
    bit   del_err;
    logic [W:0] rs;
    @(negedge clk);
    acc = 1'b0;
    del_err = 1'b0;
    if (rst_n) begin
      check_val("in_ready", {31'd0, in_ready}, (q.size() < 2 || out_ready) ? 32'd1 : 32'd0);
      if (q.size() == 0) check_val("spurious_out", {31'd0, out_valid}, 32'd0);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        check_val("sum", {23'd0, sum}, {23'd0, e.s});
        check_val("err_flag", {31'd0, err_flag}, {31'd0, e.e});
        last_lat = cyc - e.t;
        del_err = e.e;
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        rs = ref_sum(a, b, cin, mode);
        e.s = use_exp ? exp_s : rs;
        e.e = use_exp ? exp_e : (rs != SW'(a + b + cin));
        e.t = cyc;
        q.push_back(e);
      end
      if (cnt_clr) mcount = 0;
      else if (del_err && mcount < CMAX) mcount++;
    end else begin
      check_val("in_ready_rst", {31'd0, in_ready}, 32'd0);
      q.delete();
      mcount = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_val("err_count", {28'd0, err_count}, mcount);
  endtask

  task automatic send_beat(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input logic xm);
    bit acc;
    a = xa; b = xb; cin = xc; mode = xm; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(acc);
    if (!acc) check_val("accept_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic xm, input logic [W:0] es, input logic ee);
    use_exp = 1'b1; exp_s = es; exp_e = ee;
    send_beat(xa, xb, xc, xm);
    use_exp = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) step(acc);
    check_val("drain_timeout", q.size(), 32'd0);
  endtask

  initial begin
    bit acc;
    int idx;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    a = '0; b = '0; cin = 1'b0; mode = 1'b0;
    repeat (3) step(acc);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_sum", {23'd0, sum}, 32'd0);
    check_val("rst_err_flag", {31'd0, err_flag}, 32'd0);
    rst_n = 1'b1;
    step(acc);

    // Known-answer beats at W=8, L=3.
    send_exp(8'h07, 8'h01, 1'b0, 1'b1, 9'h007, 1'b1); drain();
    check_val("loa_err_count", {28'd0, err_count}, 32'd1);
    send_exp(8'h07, 8'h01, 1'b0, 1'b0, 9'h008, 1'b0); drain();
    send_exp(8'h0C, 8'h04, 1'b1, 1'b1, 9'h014, 1'b1); drain();
    send_exp(8'h0C, 8'h04, 1'b1, 1'b0, 9'h011, 1'b0); drain();
    send_exp(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b0); drain();
    check_val("latency", last_lat, 32'd2);

    // Ten back-to-back beats with the output stalled for cycles 3-6.
    idx = 0;
    for (int c = 0; c < 40 && (idx < 10 || q.size() > 0); c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (idx < 10);
      if (acc || c == 0) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); mode = 1'($urandom);
      end
      step(acc);
      if (acc) idx++;
    end
    check_val("b2b_accepted", idx, 32'd10);
    drain();

    // Saturate the counter, then clear it against a simultaneous erroneous delivery.
    a = 8'h07; b = 8'h01; cin = 1'b0; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 22; i++) step(acc);
    check_val("sat_count", {28'd0, err_count}, 32'hF);
    check_val("sat_delivering", {31'd0, out_valid & err_flag}, 32'd1);
    cnt_clr = 1'b1;
    step(acc);
    cnt_clr = 1'b0;
    check_val("clr_count", {28'd0, err_count}, 32'd0);
    drain();

    // Random traffic with random back-pressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); mode = 1'($urandom);
      end
      out_ready = 1'($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 29) == 0);
      step(acc);
    end
    cnt_clr = 1'b0;
    drain();

    // Reset with two beats in flight: nothing stale may come out afterwards.
    out_ready = 1'b0;
    send_beat(8'h33, 8'h44, 1'b0, 1'b1);
    send_beat(8'h5A, 8'h0F, 1'b1, 1'b0);
    check_val("inflight", q.size(), 32'd2);
    rst_n = 1'b0;
    step(acc);
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step(acc);
    send_beat(8'h12, 8'h34, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
